// File: rtl/k052109_cpu_vram_access.sv
// CPU-side VRAM access sequencer: captures a CPU request, waits for the next PQ slot
// edge, runs a fixed-length VRAM read/write window, then answers with a DTACK handshake.
module k052109_cpu_vram_access #(
  parameter int ADDR_W   = 13,
  parameter int ACC_LEN  = 4,
  parameter int LATCH_AT = 3,
  parameter int WE_LEN   = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              pq,
  input  logic              crcs_n,
  input  logic              cpu_rnw,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_din,
  output logic [7:0]        cpu_dout,
  output logic              cpu_dtack,
  output logic              busy,
  output logic [ADDR_W-1:0] vram_addr,
  output logic [7:0]        vram_dout,
  input  logic [7:0]        vram_din,
  output logic              vram_oe,
  output logic              vram_we
);

  // state | meaning
  // IDLE  | no request pending; waiting for crcs_n low
  // WAIT  | request captured; waiting for a pq rising edge
  // ACC   | VRAM window running, cnt = 0 .. ACC_LEN-1
  // DONE  | access complete; cpu_dtack held until crcs_n high
  typedef enum logic [1:0] {IDLE, WAIT, ACC, DONE} state_t;

  localparam logic [3:0] CNT_LAST   = 4'(ACC_LEN - 1);
  localparam logic [3:0] CNT_LATCH  = 4'(LATCH_AT);
  localparam logic [3:0] CNT_WE_END = 4'(WE_LEN);

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       abort_q, abort_nxt;
  logic       rnw_q;
  logic       pq_d;
  logic       pq_edge;
  logic       capture;

  assign pq_edge = pq & ~pq_d;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    abort_nxt = abort_q;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt   = '0;
        abort_nxt = 1'b0;
        if (!crcs_n) begin
          capture   = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (crcs_n) begin
          state_nxt = IDLE;
        end else if (pq_edge) begin
          state_nxt = ACC;
          cnt_nxt   = '0;
          abort_nxt = 1'b0;
        end
      end
      ACC: begin
        // A deselect during the window is remembered; the window still runs to the end.
        if (cnt == CNT_LAST) begin
          cnt_nxt   = '0;
          state_nxt = (abort_q || crcs_n) ? IDLE : DONE;
        end else begin
          cnt_nxt   = cnt + 4'd1;
          abort_nxt = abort_q | crcs_n;
        end
      end
      DONE: begin
        if (crcs_n) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next-state values so they line up with the state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      abort_q   <= 1'b0;
      rnw_q     <= 1'b0;
      pq_d      <= 1'b1;
      cpu_dout  <= '0;
      cpu_dtack <= 1'b0;
      busy      <= 1'b0;
      vram_addr <= '0;
      vram_dout <= '0;
      vram_oe   <= 1'b0;
      vram_we   <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      abort_q   <= abort_nxt;
      pq_d      <= pq;
      cpu_dtack <= (state_nxt == DONE);
      busy      <= (state_nxt != IDLE);
      vram_oe   <= (state_nxt == ACC) && rnw_q;
      vram_we   <= (state_nxt == ACC) && !rnw_q &&
                   (cnt_nxt >= 4'd1) && (cnt_nxt <= CNT_WE_END);
      if (capture) begin
        vram_addr <= cpu_addr;
        vram_dout <= cpu_din;
        rnw_q     <= cpu_rnw;
      end
      if ((state == ACC) && rnw_q && (cnt == CNT_LATCH)) cpu_dout <= vram_din;
    end
  end

endmodule
